// File: rtl/control_defs.sv
// ---------------------------------------------------------------------------
// control_defs
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - estado_t      : 4-bit FSM state encodings
//   - OP_* / FN_*   : supported opcodes and R-type funct codes
//   - ALU_*         : ALUSel codes driven into the ALU
//   - SRCB_* / PCSRC_* : datapath mux select codes
//   - es_retiro()   : states whose exit into FETCH completes an instruction
// ---------------------------------------------------------------------------
package control_defs;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        WB_MEM    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11
    } estado_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Last state of every legal instruction; leaving it retires the instruction.
    function automatic logic es_retiro(estado_t e);
        return e inside {WB_MEM, MEM_WRITE, R_WB, BRANCH, JUMP, I_WB};
    endfunction

endpackage

// File: rtl/decodificador_funct.sv
// ---------------------------------------------------------------------------
// decodificador_funct
// Combinational R-type funct decoder.
//   funct_i   in  6  IR[5:0]
//   alu_sel_o out 3  ALU operation for the funct (ADD when unsupported)
//   valido_o  out 1  funct is one of ADD/SUB/AND/OR/SLT
// ---------------------------------------------------------------------------
module decodificador_funct
    import control_defs::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_sel_o,
    output logic       valido_o
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_sel_o = ALU_ADD;
        valido_o  = 1'b1;
        case (funct_i)
            FN_ADD:  alu_sel_o = ALU_ADD;
            FN_SUB:  alu_sel_o = ALU_SUB;
            FN_AND:  alu_sel_o = ALU_AND;
            FN_OR:   alu_sel_o = ALU_OR;
            FN_SLT:  alu_sel_o = ALU_SLT;
            default: valido_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// ---------------------------------------------------------------------------
// control_multiciclo
// Multi-cycle main control for the MIPS-subset datapath. Moore decode of the
// registered state, except BRANCH PCWrite (from Z) and R_EXEC ALUSel (from
// Funct). While RST is high every output except Retiradas is forced to 0.
//   CLK, RST            clock, async active-high reset
//   Opcode, Funct, Z    IR fields and ALU zero flag
//   PCWrite..PCSrc      datapath selects and enables
//   Ilegal              pulse in DECODE on an unsupported instruction
//   Estado              current state (debug)
//   Retiradas           completed-instruction counter (wraps)
// ---------------------------------------------------------------------------
module control_multiciclo
    import control_defs::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Z,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUSel,
    output logic [1:0]  PCSrc,
    output logic        Ilegal,
    output logic [3:0]  Estado,
    output logic [31:0] Retiradas
);

    estado_t     estado_q, estado_d;
    logic [31:0] retiradas_q;
    logic [2:0]  funct_alu;
    logic        funct_ok;

    decodificador_funct u_decodificador_funct (
        .funct_i   (Funct),
        .alu_sel_o (funct_alu),
        .valido_o  (funct_ok)
    );

    always_comb begin
        estado_d = FETCH;
        case (estado_q)
            FETCH:  estado_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: estado_d = MEM_ADDR;
                    OP_R:         estado_d = funct_ok ? R_EXEC : FETCH;
                    OP_BEQ:       estado_d = BRANCH;
                    OP_J:         estado_d = JUMP;
                    OP_SLTI:      estado_d = I_EXEC;
                    default:      estado_d = FETCH;
                endcase
            end
            MEM_ADDR: begin
                if (Opcode == OP_LW)      estado_d = MEM_READ;
                else if (Opcode == OP_SW) estado_d = MEM_WRITE;
                else                      estado_d = FETCH;
            end
            MEM_READ: estado_d = WB_MEM;
            R_EXEC:   estado_d = R_WB;
            I_EXEC:   estado_d = I_WB;
            default:  estado_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado_q    <= FETCH;
            retiradas_q <= '0;
        end else begin
            estado_q <= estado_d;
            if (es_retiro(estado_q)) begin
                retiradas_q <= retiradas_q + 32'd1;
            end
        end
    end

    assign Retiradas = retiradas_q;

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUSel   = ALU_ADD;
        PCSrc    = PCSRC_ALU;
        Ilegal   = 1'b0;
        Estado   = 4'd0;
        // Reset masks everything so no strobe survives an abandoned instruction.
        if (!RST) begin
            Estado = estado_q;
            case (estado_q)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_4;
                end
                DECODE: begin
                    ALUSrcB = SRCB_IMM_SH;
                    // Only an unsupported instruction falls straight back to FETCH.
                    Ilegal  = (estado_d == FETCH);
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSel  = funct_alu;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUSel  = ALU_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    // An unknown Z compares as not-true, so the branch is not taken.
                    if (Z == 1'b1) PCWrite = 1'b1;
                end
                JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUSel  = ALU_SLT;
                end
                I_WB: begin
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_control_multiciclo
// Self-checking bench: directed scenarios followed by random instructions,
// each compared cycle by cycle with a per-instruction reference plan.
// ---------------------------------------------------------------------------
module tb_control_multiciclo;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Opcode, Funct;
    logic        Z;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg;
    logic        RegWrite, ALUSrcA, Ilegal;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUSel;
    logic [3:0]  Estado;
    logic [31:0] Retiradas;

    control_multiciclo dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Z(Z),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUSel(ALUSel), .PCSrc(PCSrc), .Ilegal(Ilegal), .Estado(Estado),
        .Retiradas(Retiradas)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] est;
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic       ileg;
    } paso_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cuenta;       // model of the retired-instruction counter
    paso_t       plan_q[$];    // expected outputs, one entry per cycle
    logic        plan_retira;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observado();
        paso_t o;
        o = '{est: Estado, pcw: PCWrite, iord: IorD, mrd: MemRead, mwr: MemWrite,
              irw: IRWrite, rdst: RegDst, m2r: MemToReg, rw: RegWrite,
              srca: ALUSrcA, srcb: ALUSrcB, alu: ALUSel, pcsrc: PCSrc, ileg: Ilegal};
        return {11'd0, o};
    endfunction

    function automatic logic [31:0] empaca(input paso_t p);
        return {11'd0, p};
    endfunction

    // Funct table from the instruction set: operation and legality.
    function automatic logic [3:0] ref_funct(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 3'b000};
            6'b100010: return {1'b1, 3'b001};
            6'b100100: return {1'b1, 3'b010};
            6'b100101: return {1'b1, 3'b011};
            6'b101010: return {1'b1, 3'b100};
            default:   return {1'b0, 3'b000};
        endcase
    endfunction

    // Builds the whole cycle-by-cycle expectation for one instruction.
    task automatic planificar(input logic [5:0] op, input logic [5:0] fn, input logic z);
        paso_t       p;
        logic [3:0]  rf;
        logic        legal;
        rf = ref_funct(fn);
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
                (op == 6'b000010) || (op == 6'b001010) || (op == 6'b000000 && rf[3]);
        plan_q.delete();
        p = '0; p.est = 4'd0; p.mrd = 1; p.irw = 1; p.pcw = 1; p.srcb = 2'b01;
        plan_q.push_back(p);
        p = '0; p.est = 4'd1; p.srcb = 2'b11; p.ileg = !legal;
        plan_q.push_back(p);
        plan_retira = legal;
        if (legal) begin
            case (op)
                6'b100011, 6'b101011: begin
                    p = '0; p.est = 4'd2; p.srca = 1; p.srcb = 2'b10;
                    plan_q.push_back(p);
                    if (op == 6'b100011) begin
                        p = '0; p.est = 4'd3; p.mrd = 1; p.iord = 1;
                        plan_q.push_back(p);
                        p = '0; p.est = 4'd4; p.rw = 1; p.m2r = 1;
                        plan_q.push_back(p);
                    end else begin
                        p = '0; p.est = 4'd5; p.mwr = 1; p.iord = 1;
                        plan_q.push_back(p);
                    end
                end
                6'b000000: begin
                    p = '0; p.est = 4'd6; p.srca = 1; p.alu = rf[2:0];
                    plan_q.push_back(p);
                    p = '0; p.est = 4'd7; p.rw = 1; p.rdst = 1;
                    plan_q.push_back(p);
                end
                6'b000100: begin
                    p = '0; p.est = 4'd8; p.srca = 1; p.alu = 3'b001;
                    p.pcsrc = 2'b01; p.pcw = z;
                    plan_q.push_back(p);
                end
                6'b000010: begin
                    p = '0; p.est = 4'd9; p.pcsrc = 2'b10; p.pcw = 1;
                    plan_q.push_back(p);
                end
                default: begin
                    p = '0; p.est = 4'd10; p.srca = 1; p.srcb = 2'b10; p.alu = 3'b100;
                    plan_q.push_back(p);
                    p = '0; p.est = 4'd11; p.rw = 1;
                    plan_q.push_back(p);
                end
            endcase
        end
    endtask

    // Called #1 after a rising edge with the DUT in FETCH. preload_paso >= 0
    // forces the counter to all-ones at that step to reach the wrap point.
    task automatic ejecutar(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int preload_paso);
        paso_t p;
        int    k;
        Opcode = op; Funct = fn; Z = z;
        planificar(op, fn, z);
        k = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            if (k == preload_paso) begin
                force dut.retiradas_q = 32'hFFFF_FFFF;
                #1;
                release dut.retiradas_q;
                cuenta = 32'hFFFF_FFFF;
            end
            @(negedge CLK);
            check($sformatf("%s.ctl%0d", tag, k), observado(), empaca(p));
            check($sformatf("%s.ret%0d", tag, k), Retiradas, cuenta);
            @(posedge CLK);
            #1;
            k++;
        end
        if (plan_retira) cuenta = cuenta + 32'd1;
    endtask

    initial begin
        paso_t p;
        logic [5:0] op, fn;
        RST = 1'b1; Opcode = 6'b100011; Funct = 6'b0; Z = 1'b1;
        cuenta = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.ctl", observado(), 32'd0);
        check("reset.ret", Retiradas, 32'd0);
        RST = 1'b0;

        ejecutar("lw",       6'b100011, 6'b000000, 1'b0, -1);
        ejecutar("r_sub",    6'b000000, 6'b100010, 1'b0, -1);
        ejecutar("beq_z1",   6'b000100, 6'b000000, 1'b1, -1);
        ejecutar("beq_z0",   6'b000100, 6'b000000, 1'b0, -1);
        ejecutar("ilegal_op",6'b111111, 6'b100000, 1'b0, -1);
        ejecutar("ilegal_fn",6'b000000, 6'b000000, 1'b0, -1);
        ejecutar("slti",     6'b001010, 6'b000000, 1'b0, -1);
        ejecutar("sw",       6'b101011, 6'b000000, 1'b0, -1);

        // SW abandoned by reset during MEM_WRITE.
        Opcode = 6'b101011; Funct = 6'b0; Z = 1'b0;
        planificar(6'b101011, 6'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            p = plan_q.pop_front();
            @(negedge CLK);
            check($sformatf("sw_rst.ctl%0d", k), observado(), empaca(p));
            @(posedge CLK);
            #1;
        end
        p = plan_q.pop_front();
        #1;
        check("sw_rst.memwrite", observado(), empaca(p));
        RST = 1'b1;
        #1;
        check("sw_rst.ctl_in_reset", observado(), 32'd0);
        check("sw_rst.ret_in_reset", Retiradas, 32'd0);
        cuenta = '0;
        @(posedge CLK);
        #1;
        check("sw_rst.ctl_held", observado(), 32'd0);
        RST = 1'b0;
        plan_q.delete();
        ejecutar("after_rst", 6'b000010, 6'b000000, 1'b0, -1);

        // Counter wrap: preload all-ones in the JUMP cycle, then one more J.
        ejecutar("j_preload", 6'b000010, 6'b000000, 1'b0, 2);
        ejecutar("j_wrap",    6'b000010, 6'b000000, 1'b0, -1);
        check("wrap.ret", Retiradas, 32'd1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b001010;
                5: op = 6'b000010;
                6: op = 6'($urandom);
                default: op = 6'b000000;
            endcase
            case ($urandom_range(0, 6))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            ejecutar($sformatf("rnd%0d", n), op, fn, 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
